// File: rtl/field_ordering_pkg.sv
// Shared types and sizing helpers for the field-ordering sequencer
// and its output FIFO.
package field_ordering_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SORT,
    WAIT,
    READ,
    FAIL
  } fo_state_t;

  localparam int FO_M_DEF         = 13;
  localparam int FO_SIGMA2_DEF    = 32;
  localparam int FO_MAX_RETRY_DEF = 4;
  localparam int FO_RD_LAT_DEF    = 1;

  function automatic int fo_n(input int m);
    return 1 << m;
  endfunction

  function automatic int fo_att_w(input int max_retry);
    return $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/fo_out_fifo2.sv
// Two-entry FIFO that absorbs sort-engine read latency so the alpha
// stream can run at full rate under arbitrary backpressure.
module fo_out_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wp_q;
  logic         rp_q;
  logic [1:0]   cnt_q;
  logic         push;
  logic         pop;

  assign push        = in_valid_i && (cnt_q != 2'd2);
  assign pop         = out_valid_o && out_ready_i;
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rp_q];
  assign count_o     = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= in_data_i;
        wp_q        <= ~wp_q;
      end
      if (pop) begin
        rp_q <= ~rp_q;
      end
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/field_ordering_ctrl.sv
// Load/sort/readout sequencer around the field-ordering sort engine,
// with reload-and-retry when the engine reports equal keys.
module field_ordering_ctrl
  import field_ordering_pkg::*;
#(
  parameter int M         = FO_M_DEF,
  parameter int SIGMA2    = FO_SIGMA2_DEF,
  parameter int MAX_RETRY = FO_MAX_RETRY_DEF,
  parameter int RD_LAT    = FO_RD_LAT_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             fail,
  input  logic                             rand_valid,
  output logic                             rand_ready,
  input  logic [SIGMA2-1:0]                rand_data,
  output logic                             fo_wr_en,
  output logic [M-1:0]                     fo_wr_addr,
  output logic [SIGMA2-1:0]                fo_rand_in,
  output logic                             fo_start,
  input  logic                             fo_done,
  input  logic                             fo_fail,
  output logic                             fo_rd_en,
  output logic [M-1:0]                     fo_rd_addr,
  input  logic [M-1:0]                     fo_index_out,
  output logic                             alpha_valid,
  input  logic                             alpha_ready,
  output logic [M-1:0]                     alpha_out,
  output logic [fo_att_w(MAX_RETRY)-1:0]   attempts
);

  localparam int N  = fo_n(M);
  localparam int CW = M + 1;
  localparam int AW = fo_att_w(MAX_RETRY);

  localparam logic [CW-1:0] LAST  = CW'(N - 1);
  localparam logic [AW-1:0] MAX_A = AW'(MAX_RETRY);

  fo_state_t         state_q;
  logic [CW-1:0]     wr_cnt_q;
  logic [CW-1:0]     rd_cnt_q;
  logic [CW-1:0]     out_cnt_q;
  logic [AW-1:0]     attempts_q;
  logic              fail_q;
  logic              done_q;
  logic [RD_LAT-1:0] lat_q;

  logic       wr_fire;
  logic       rd_fire;
  logic       pop;
  logic [1:0] fifo_cnt;
  logic [2:0] infl;
  logic [2:0] occ;

  assign rand_ready = (state_q == LOAD);
  assign wr_fire    = rand_ready && rand_valid;
  assign fo_wr_en   = wr_fire;
  assign fo_wr_addr = wr_fire ? wr_cnt_q[M-1:0] : '0;
  assign fo_rand_in = wr_fire ? rand_data : '0;
  assign fo_start   = (state_q == SORT);

  assign busy     = !(state_q inside {IDLE, FAIL});
  assign done     = done_q;
  assign fail     = fail_q;
  assign attempts = attempts_q;

  // Credit: buffered + in flight, less what leaves this cycle, stays <= 2.
  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      infl = infl + {2'b00, lat_q[i]};
    end
  end

  assign pop     = alpha_valid && alpha_ready;
  assign occ     = {1'b0, fifo_cnt} + infl - {2'b00, pop};
  assign rd_fire = (state_q == READ) && !rd_cnt_q[M] && (occ < 3'd2);

  assign fo_rd_en   = rd_fire;
  assign fo_rd_addr = rd_fire ? rd_cnt_q[M-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_q <= '0;
    end else begin
      lat_q <= (lat_q << 1) | RD_LAT'(rd_fire);
    end
  end

  fo_out_fifo2 #(
    .W (M)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (lat_q[RD_LAT-1]),
    .in_data_i   (fo_index_out),
    .out_valid_o (alpha_valid),
    .out_ready_i (alpha_ready),
    .out_data_o  (alpha_out),
    .count_o     (fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      attempts_q <= '0;
      fail_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            fail_q     <= 1'b0;
            attempts_q <= '0;
            wr_cnt_q   <= '0;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          if (wr_fire) begin
            wr_cnt_q <= wr_cnt_q + CW'(1);
            if (wr_cnt_q == LAST) begin
              state_q <= SORT;
            end
          end
        end
        SORT: begin
          attempts_q <= attempts_q + AW'(1);
          rd_cnt_q   <= '0;
          out_cnt_q  <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (fo_done) begin
            if (!fo_fail) begin
              state_q <= READ;
            end else if (attempts_q < MAX_A) begin
              wr_cnt_q <= '0;
              state_q  <= LOAD;
            end else begin
              fail_q  <= 1'b1;
              state_q <= FAIL;
            end
          end
        end
        READ: begin
          if (rd_fire) begin
            rd_cnt_q <= rd_cnt_q + CW'(1);
          end
          if (pop) begin
            out_cnt_q <= out_cnt_q + CW'(1);
            if (out_cnt_q == LAST) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        FAIL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
